// File: rtl/transfer_arbiter.sv
// Round-robin arbiter that lends one transfer-center serial input to N_REQ scanners,
// passing the granted scanner's bit stream through while counting bits and bytes.
module transfer_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned BYTES_PER_XFER = 8,
    parameter int unsigned TIMEOUT        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           bit_valid,
    input  logic [N_REQ-1:0]           serial_in,
    input  logic                       tc_ready,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   active_id,
    output logic                       xfer_start,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic [2:0]                 bit_count,
    output logic [7:0]                 byte_count,
    output logic                       byte_done,
    output logic                       xfer_done,
    output logic                       timeout_err
);

    localparam int unsigned IdW   = $clog2(N_REQ);
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWaitTc = 2'd1;
    localparam logic [1:0] StXfer   = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IdW-1:0]   active_id_q, active_id_d;
    logic [IdW-1:0]   last_grant_q, last_grant_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_cnt_q, byte_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             xfer_start_q, xfer_start_d;
    logic             byte_done_q, byte_done_d;
    logic             xfer_done_q, xfer_done_d;
    logic             timeout_err_q, timeout_err_d;

    logic             rr_found;
    logic [IdW-1:0]   rr_idx;
    logic [IdW-1:0]   rr_cand;
    logic [N_REQ-1:0] rr_onehot;
    logic             in_xfer;
    logic             strobe;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            rr_cand = IdW'((32'(last_grant_q) + i) % N_REQ);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
        rr_onehot = '0;
        if (rr_found) begin
            rr_onehot[rr_idx] = 1'b1;
        end
    end

    assign in_xfer   = (state_q == StXfer);
    assign strobe    = in_xfer & bit_valid[active_id_q];
    assign ser_valid = strobe;
    assign ser_out   = in_xfer & serial_in[active_id_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        active_id_d   = active_id_q;
        last_grant_d  = last_grant_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        xfer_start_d  = 1'b0;
        byte_done_d   = 1'b0;
        xfer_done_d   = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    grant_d     = rr_onehot;
                    active_id_d = rr_idx;
                    state_d     = StWaitTc;
                end
            end
            StWaitTc: begin
                if (tc_ready) begin
                    state_d      = StXfer;
                    xfer_start_d = 1'b1;
                    bit_cnt_d    = '0;
                    byte_cnt_d   = '0;
                    idle_cnt_d   = '0;
                end
            end
            StXfer: begin
                // A strobe always clears the idle count, so it beats a same-cycle timeout.
                if (strobe) begin
                    idle_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d  = byte_cnt_q + 8'd1;
                        byte_done_d = 1'b1;
                        if (byte_cnt_q == 8'(BYTES_PER_XFER - 1)) begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + IdleW'(1);
                    if (idle_cnt_q == IdleW'(TIMEOUT - 1)) begin
                        timeout_err_d = 1'b1;
                        grant_d       = '0;
                        last_grant_d  = active_id_q;
                        active_id_d   = '0;
                        state_d       = StIdle;
                    end
                end
            end
            StDone: begin
                xfer_done_d  = 1'b1;
                grant_d      = '0;
                last_grant_d = active_id_q;
                active_id_d  = '0;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            active_id_q   <= '0;
            last_grant_q  <= IdW'(N_REQ - 1);
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            xfer_start_q  <= 1'b0;
            byte_done_q   <= 1'b0;
            xfer_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            active_id_q   <= active_id_d;
            last_grant_q  <= last_grant_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            xfer_start_q  <= xfer_start_d;
            byte_done_q   <= byte_done_d;
            xfer_done_q   <= xfer_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant       = grant_q;
    assign active_id   = active_id_q;
    assign xfer_start  = xfer_start_q;
    assign bit_count   = bit_cnt_q;
    assign byte_count  = byte_cnt_q;
    assign byte_done   = byte_done_q;
    assign xfer_done   = xfer_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_transfer_arbiter.sv
// Randomized bench for transfer_arbiter: a transfer-level model feeds scoreboard queues
// that a negedge monitor drains whenever the DUT presents a grant, bit or pulse.
module tb_transfer_arbiter;

    localparam int N  = 4;
    localparam int NB = 8;
    localparam int TO = 16;

    typedef struct {
        bit tmo;
        int cyc;
        int bits;
        int bytes;
    } end_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] bit_valid;
    logic [N-1:0] serial_in;
    logic         tc_ready;
    logic [N-1:0] grant;
    logic [1:0]   active_id;
    logic         xfer_start;
    logic         ser_out;
    logic         ser_valid;
    logic [2:0]   bit_count;
    logic [7:0]   byte_count;
    logic         byte_done;
    logic         xfer_done;
    logic         timeout_err;

    transfer_arbiter #(
        .N_REQ          (N),
        .BYTES_PER_XFER (NB),
        .TIMEOUT        (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .bit_valid   (bit_valid),
        .serial_in   (serial_in),
        .tc_ready    (tc_ready),
        .grant       (grant),
        .active_id   (active_id),
        .xfer_start  (xfer_start),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .bit_count   (bit_count),
        .byte_count  (byte_count),
        .byte_done   (byte_done),
        .xfer_done   (xfer_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    int   model_last = N - 1;
    int   exp_grant_q[$];
    int   exp_start_q[$];
    int   exp_bit_q[$];
    end_t exp_end_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            if (r[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic noise(input int w, input bit quiet);
        bit_valid = N'($urandom);
        serial_in = N'($urandom);
        if (quiet) bit_valid[w] = 1'b0;
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({grant, active_id, xfer_start, ser_out, ser_valid, bit_count, byte_count,
                    byte_done, xfer_done, timeout_err});
    endfunction

    // mode 0: full transfer, 1: stall into timeout after nb_in bits, 2: reset after nb_in bits
    task automatic run_xfer(input logic [N-1:0] r, input int mode, input int k_in,
                            input int nb_in, input bit use_a5);
        int         w;
        int         k;
        int         nbits;
        int         gap;
        int         last_act;
        int         c;
        logic [7:0] pat;
        bit         b;
        end_t       e;
        pat = 8'hA5;
        w = rr_pick(r, model_last);
        req = r;
        exp_grant_q.push_back(w);
        c = 0;
        do begin
            noise(w, 1'b0);
            tc_ready = 1'($urandom);
            @(posedge clk); #1;
            c++;
        end while (grant == '0 && c < 20);
        check("grant_wait", 32'(grant != '0), 1);
        k = (k_in < 0) ? $urandom_range(0, 4) : k_in;
        tc_ready = 1'b0;
        repeat (k) begin
            noise(w, 1'b0);
            @(posedge clk); #1;
        end
        tc_ready = 1'b1;
        exp_start_q.push_back(cyc + 1);
        noise(w, 1'b0);
        @(posedge clk); #1;
        last_act = cyc - 1;
        nbits = (mode == 0) ? NB * 8 : ((nb_in < 0) ? $urandom_range(0, NB * 8 - 1) : nb_in);
        for (int i = 0; i < nbits; i++) begin
            gap = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 3);
            repeat (gap) begin
                noise(w, 1'b1);
                tc_ready = 1'($urandom);
                @(posedge clk); #1;
            end
            b = use_a5 ? pat[i % 8] : 1'($urandom);
            noise(w, 1'b1);
            bit_valid[w] = 1'b1;
            serial_in[w] = b;
            tc_ready = 1'($urandom);
            exp_bit_q.push_back(int'(b));
            last_act = cyc;
            if (mode == 2 && i == nbits - 1) begin
                #2 rst = 1'b0;
                #1 check("reset_midxfer_outputs", all_outputs(), 0);
                exp_grant_q.delete();
                exp_start_q.delete();
                exp_bit_q.delete();
                exp_end_q.delete();
                model_last = N - 1;
                @(posedge clk); #1;
                rst = 1'b1;
                bit_valid = '0;
                return;
            end
            @(posedge clk); #1;
        end
        e.tmo   = (mode == 1);
        e.bits  = nbits % 8;
        e.bytes = nbits / 8;
        e.cyc   = (mode == 1) ? last_act + TO + 1 : last_act + 2;
        exp_end_q.push_back(e);
        c = 0;
        do begin
            noise(w, mode == 1);
            @(posedge clk); #1;
            c++;
        end while (!(xfer_done || timeout_err) && c < 3 * TO);
        check("end_wait", 32'(xfer_done || timeout_err), 1);
        model_last = w;
    endtask

    logic [N-1:0] prev_grant;
    int           bd_cnt;

    always @(negedge clk) begin
        int   w;
        int   eb;
        int   es;
        end_t e;
        if (!rst) begin
            prev_grant = '0;
            bd_cnt = 0;
        end else begin
            if (grant != '0 && prev_grant == '0) begin
                if (exp_grant_q.size() != 0) w = exp_grant_q.pop_front();
                else w = -1;
                check("grant", 32'(grant), (w < 0) ? 32'd0 : (32'd1 << w));
                check("active_id", 32'(active_id), (w < 0) ? 32'd0 : 32'(w));
            end else if (grant != '0) begin
                check("grant_hold", 32'(grant), 32'(prev_grant));
            end
            if (ser_valid) begin
                if (exp_bit_q.size() != 0) eb = exp_bit_q.pop_front();
                else eb = 2;
                check("ser_out", 32'(ser_out), 32'(eb));
            end
            if (xfer_start) begin
                if (exp_start_q.size() != 0) es = exp_start_q.pop_front();
                else es = -1;
                check("xfer_start_cycle", 32'(cyc), 32'(es));
            end
            if (byte_done) bd_cnt++;
            if (xfer_done || timeout_err) begin
                if (exp_end_q.size() != 0) e = exp_end_q.pop_front();
                else e = '{tmo: 1'b0, cyc: -1, bits: 0, bytes: 0};
                check("end_kind", 32'({xfer_done, timeout_err}), 32'({!e.tmo, e.tmo}));
                check("end_cycle", 32'(cyc), 32'(e.cyc));
                check("end_bit_count", 32'(bit_count), 32'(e.bits));
                check("end_byte_count", 32'(byte_count), 32'(e.bytes));
                check("byte_done_pulses", 32'(bd_cnt), 32'(e.bytes));
                check("grant_released", 32'(grant), 0);
                bd_cnt = 0;
            end
            prev_grant = grant;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        bit_valid = '0;
        serial_in = '0;
        tc_ready = 1'b0;
        #1 rst = 1'b0;
        req = 4'b1111;
        tc_ready = 1'b1;
        bit_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", all_outputs(), 0);
        rst = 1'b1;

        run_xfer(4'b0101, 0, 0, 0, 1'b1);
        run_xfer(4'b0101, 0, -1, 0, 1'b0);
        repeat (4) run_xfer(4'b1111, 0, -1, 0, 1'b0);
        run_xfer(4'b1111, 0, 5, 0, 1'b0);
        run_xfer(4'b0110, 1, 2, 3, 1'b0);
        run_xfer(4'b1111, 1, 0, 0, 1'b0);
        run_xfer(4'b1011, 2, 1, 20, 1'b0);
        run_xfer(4'b1111, 0, 0, 0, 1'b0);
        for (int t = 0; t < 10; t++) begin
            run_xfer(N'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                     -1, -1, 1'b0);
        end

        bit_valid = '0;
        req = '0;
        repeat (5) @(posedge clk);
        #1;
        check("grant_queue_empty", 32'(exp_grant_q.size()), 0);
        check("start_queue_empty", 32'(exp_start_q.size()), 0);
        check("bit_queue_empty", 32'(exp_bit_q.size()), 0);
        check("end_queue_empty", 32'(exp_end_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
